// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC, pipelined req/gnt + rvalid imem port, prefetch FIFO, redirect with stale-response discard.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_bubble_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [31:0] fetch_pc;
  logic [31:0] head_pc;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  cnt_t        fifo_count;
  cnt_t        outstanding;
  cnt_t        discard;

  logic        issue;
  logic        resp;
  logic        drop;
  logic        push;
  logic        pop;
  logic [CW:0] credit_used;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign redirect_target      = {i_redirect_pc[31:2], 2'b00};

  // Every FIFO slot is reserved either by a stored instruction or by a request in flight.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

  always_comb begin
    o_imem_req = rst_n & ~i_redirect & (credit_used < DEPTH);
    issue      = o_imem_req & i_imem_gnt;
    // A response with nothing outstanding cannot be ours; ignoring it keeps the counters from underflowing.
    resp       = i_imem_rvalid & (outstanding != '0);
    drop       = resp & (i_redirect | (discard != '0));
    push       = resp & ~drop;
    o_valid    = (fifo_count != '0);
    pop        = o_valid & ~i_stall & ~i_redirect;
    o_imem_addr = fetch_pc;
    o_pc        = head_pc;
    o_instr     = o_valid ? fifo_mem[rd_ptr] : NOP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (i_redirect) begin
      // Flush and restart; every response still in flight after this cycle is stale.
      fetch_pc    <= redirect_target;
      head_pc     <= redirect_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= outstanding - cnt_t'(resp);
      discard     <= outstanding - cnt_t'(resp);
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (pop) begin
        head_pc <= head_pc + 32'd4;
        rd_ptr  <= rd_ptr + ptr_t'(1);
      end
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      fifo_count  <= fifo_count + cnt_t'(push) - cnt_t'(pop);
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(resp);
      if (drop) discard <= discard - cnt_t'(1);
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only observable once fifo_count covers them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= i_imem_rdata;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_bubble_cnt <= '0;
      o_flush_cnt  <= '0;
    end else begin
      if (!o_valid && !i_redirect) o_bubble_cnt <= o_bubble_cnt + 32'd1;
      if (drop)                    o_flush_cnt  <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a cycle table for straight-line fetch plus directed
// stall / redirect / reset / wrap sequences against a latency-configurable memory model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
  int          exp_flush;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_valid       (o_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .o_bubble_cnt  (bubble_cnt),
    .o_flush_cnt   (flush_cnt)
`endif
  );

  // Memory model: always grants; a grant in cycle t returns addr|0x100 in cycle t+lat.
  int          lat;
  logic        pipe_v [4];
  logic [31:0] pipe_a [4];

  assign i_imem_gnt    = 1'b1;
  assign i_imem_rvalid = pipe_v[lat-1];
  assign i_imem_rdata  = pipe_a[lat-1] | 32'h100;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= o_imem_req & i_imem_gnt;
      pipe_a[0] <= o_imem_addr;
      for (int i = 1; i < 4; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  int          n_vec;
  int          n_err;
  logic [31:0] exp_pc;
  logic        prev_redir;
  logic [31:0] prev_target;
  int          pops;
  logic        s_req;
  logic        s_valid;
  logic [31:0] issued_addrs [$];

  typedef struct {
    logic        stall;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle with the in-order scoreboard: valid output must be the next expected PC.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc);
    int pending;
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    @(negedge clk);
    if (prev_redir) begin
      check("post_redirect_valid", {31'd0, o_valid}, 32'd0);
      check("post_redirect_addr", o_imem_addr, prev_target);
      check("post_redirect_pc", o_pc, prev_target);
    end
    if (redir) begin
      check("redirect_cycle_req", {31'd0, o_imem_req}, 32'd0);
      pending = 0;
      for (int i = 0; i < lat; i++) pending += int'(pipe_v[i]);
`ifdef IF_PERF_CNT_EN
      exp_flush += pending;
`endif
    end
    if (o_valid) begin
      check("seq_pc", o_pc, exp_pc);
      check("seq_instr", o_instr, exp_pc | 32'h100);
    end else begin
      check("idle_instr_nop", o_instr, NOP);
    end
    if (o_imem_req) issued_addrs.push_back(o_imem_addr);
    s_req   = o_imem_req;
    s_valid = o_valid;
    if (redir) exp_pc = {rpc[31:2], 2'b00};
    else if (o_valid && !stall) begin
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    prev_redir  = redir;
    prev_target = {rpc[31:2], 2'b00};
    @(posedge clk);
    #1;
  endtask

  // Reset is held across two edges with a redirect also asserted: reset must win.
  task automatic do_reset(input int new_lat);
    i_stall       = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    rst_n         = 1'b0;
    lat           = new_lat;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_instr", o_instr, NOP);
    check("rst_pc", o_pc, RESET_PC);
    check("rst_req", {31'd0, o_imem_req}, 32'd0);
    check("rst_addr", o_imem_addr, RESET_PC);
`ifdef IF_PERF_CNT_EN
    check("rst_bubble_cnt", bubble_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    exp_flush = 0;
`endif
    @(posedge clk);
    #1;
    i_redirect = 1'b0;
    rst_n      = 1'b1;
    exp_pc     = RESET_PC;
    prev_redir = 1'b0;
    pops       = 0;
    issued_addrs.delete();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    i_stall = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    lat = 1;

    // Straight-line fetch, 1-cycle latency: credit limit gives a valid/valid/bubble rhythm.
    tbl[0] = '{1'b0, 1'b0, 32'd0,  NOP,          1'b1, 32'd0};
    tbl[1] = '{1'b0, 1'b0, 32'd0,  NOP,          1'b1, 32'd4};
    tbl[2] = '{1'b0, 1'b1, 32'd0,  32'h100,      1'b0, 32'd8};
    tbl[3] = '{1'b0, 1'b1, 32'd4,  32'h104,      1'b1, 32'd8};
    tbl[4] = '{1'b0, 1'b0, 32'd8,  NOP,          1'b1, 32'd12};
    tbl[5] = '{1'b0, 1'b1, 32'd8,  32'h108,      1'b0, 32'd16};
    tbl[6] = '{1'b0, 1'b1, 32'd12, 32'h10c,      1'b1, 32'd16};
    tbl[7] = '{1'b0, 1'b0, 32'd16, NOP,          1'b1, 32'd20};
    tbl[8] = '{1'b0, 1'b1, 32'd16, 32'h110,      1'b0, 32'd24};

    do_reset(1);

    for (int k = 0; k < 9; k++) begin
      i_stall = tbl[k].stall;
      @(negedge clk);
      check($sformatf("t1[%0d].valid", k), {31'd0, o_valid}, {31'd0, tbl[k].exp_valid});
      check($sformatf("t1[%0d].pc", k), o_pc, tbl[k].exp_pc);
      check($sformatf("t1[%0d].instr", k), o_instr, tbl[k].exp_instr);
      check($sformatf("t1[%0d].req", k), {31'd0, o_imem_req}, {31'd0, tbl[k].exp_req});
      check($sformatf("t1[%0d].addr", k), o_imem_addr, tbl[k].exp_addr);
      @(posedge clk);
      #1;
    end
`ifdef IF_PERF_CNT_EN
    check("t1_bubble_cnt", bubble_cnt, 32'd4);
`endif
    exp_pc = 32'd20;

    // Backpressure: hold stall, FIFO fills and the request drops; then resume in order.
    pops = 0;
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 32'd0);
    check("t2_full_req", {31'd0, s_req}, 32'd0);
    check("t2_full_valid", {31'd0, s_valid}, 32'd1);
    check("t2_no_pop_in_stall", pops, 32'd0);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'd0);
    check("t2_progress", {31'd0, pops >= 5}, 32'd1);

    // Redirect with two requests in flight (3-cycle latency); low target bits are ignored.
    do_reset(3);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0000_0083);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 32'd0);
    check("t3_progress", {31'd0, pops >= 3}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("t3_flush_cnt", flush_cnt, exp_flush);
`endif

    // Redirect coincident with stall and a returning response, two outstanding.
    do_reset(3);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    check("t4_rvalid_in_redirect", {31'd0, i_imem_rvalid}, 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0040);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 32'd0);
    check("t4_progress", {31'd0, pops >= 3}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("t4_flush_cnt", flush_cnt, exp_flush);
`endif

    // Reset mid-operation with the FIFO filled by a stall.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 32'd0);
    check("t5_valid_before_reset", {31'd0, s_valid}, 32'd1);
    do_reset(1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'd0);
    check("t5_progress", {31'd0, pops >= 2}, 32'd1);

    // Back-to-back redirects (first under stall), the last one targets the top word: PC wraps.
    cycle(1'b1, 1'b1, 32'h0000_0300);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    issued_addrs.delete();
    pops = 0;
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 32'd0);
    if (issued_addrs.size() >= 2) begin
      check("t6_first_issue", issued_addrs[0], 32'hFFFF_FFFC);
      check("t6_wrapped_issue", issued_addrs[1], 32'h0000_0000);
    end else begin
      check("t6_issue_count", issued_addrs.size(), 32'd2);
    end
    check("t6_progress", {31'd0, pops >= 3}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("t6_flush_cnt", flush_cnt, exp_flush);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
